// File: rtl/gnrl_delay_meter.sv
// gnrl_delay_meter: measures the cycle delay from a SIG_REF rising edge to the
// next SIG_ECHO rising edge, then the SIG_ECHO high-time. Results are presented
// together with a one-cycle valid strobe and held until the next result.
// Optional build macro GNRL_DELAY_METER_SYNC_EN adds a two-flop synchronizer
// on both inputs ahead of the edge-detect stage for asynchronous sources.
module gnrl_delay_meter #(
    parameter int DELAY_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   sig_ref_i,
    input  logic                   sig_echo_i,
    input  logic [DELAY_WIDTH-1:0] timeout_i,
    output logic [DELAY_WIDTH-1:0] delay_out_o,
    output logic [DELAY_WIDTH-1:0] width_out_o,
    output logic                   valid_o,
    output logic                   timed_out_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_ECHO  = 2'd1,
        ST_MEAS_WIDTH = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    localparam logic [DELAY_WIDTH-1:0] CNT_ZERO = {DELAY_WIDTH{1'b0}};
    localparam logic [DELAY_WIDTH-1:0] CNT_ONE  = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DELAY_WIDTH-1:0] CNT_MAX  = {DELAY_WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic ref_in_s;
    logic echo_in_s;

`ifdef GNRL_DELAY_METER_SYNC_EN
    logic ref_sync0_q, ref_sync1_q;
    logic echo_sync0_q, echo_sync1_q;

    // Two-flop synchronizer for asynchronous transducer inputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ref_sync0_q  <= 1'b0;
            ref_sync1_q  <= 1'b0;
            echo_sync0_q <= 1'b0;
            echo_sync1_q <= 1'b0;
        end else begin
            ref_sync0_q  <= sig_ref_i;
            ref_sync1_q  <= ref_sync0_q;
            echo_sync0_q <= sig_echo_i;
            echo_sync1_q <= echo_sync0_q;
        end
    end

    assign ref_in_s  = ref_sync1_q;
    assign echo_in_s = echo_sync1_q;
`else
    assign ref_in_s  = sig_ref_i;
    assign echo_in_s = sig_echo_i;
`endif

    logic ref_r1_q, ref_r2_q, echo_r1_q, echo_r2_q;
    logic ref_rise_s, echo_rise_s, echo_fall_s;

    // Edge-detect registers; identical depth on both inputs keeps differences exact
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ref_r1_q  <= 1'b0;
            ref_r2_q  <= 1'b0;
            echo_r1_q <= 1'b0;
            echo_r2_q <= 1'b0;
        end else begin
            ref_r1_q  <= ref_in_s;
            ref_r2_q  <= ref_r1_q;
            echo_r1_q <= echo_in_s;
            echo_r2_q <= echo_r1_q;
        end
    end

    assign ref_rise_s  = ref_r1_q & ~ref_r2_q;
    assign echo_rise_s = echo_r1_q & ~echo_r2_q;
    assign echo_fall_s = ~echo_r1_q & echo_r2_q;

    // ------------------------------------------------------------------
    // Measurement FSM and datapath
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
    logic [DELAY_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [DELAY_WIDTH-1:0] tmo_cap_q, tmo_cap_d;
    logic [DELAY_WIDTH-1:0] delay_cap_q, delay_cap_d;
    logic [DELAY_WIDTH-1:0] width_cap_q, width_cap_d;
    logic                   tflag_cap_q, tflag_cap_d;
    logic [DELAY_WIDTH-1:0] delay_out_q, delay_out_d;
    logic [DELAY_WIDTH-1:0] width_out_q, width_out_d;
    logic                   valid_q, valid_d;
    logic                   timed_out_q, timed_out_d;
    logic                   busy_q, busy_d;
    logic                   tmo_hit_s;

    // Timeout fires only when a non-zero limit was captured and the count reached it
    assign tmo_hit_s = (tmo_cap_q != CNT_ZERO) && (cnt_q == tmo_cap_q);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; echo rise wins over a simultaneous timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ref_rise_s && echo_rise_s) state_d = ST_MEAS_WIDTH;
                else if (ref_rise_s)           state_d = ST_WAIT_ECHO;
                else                           state_d = ST_IDLE;
            end
            ST_WAIT_ECHO: begin
                if (echo_rise_s)    state_d = ST_MEAS_WIDTH;
                else if (tmo_hit_s) state_d = ST_DONE;
                else                state_d = ST_WAIT_ECHO;
            end
            ST_MEAS_WIDTH: begin
                if (echo_fall_s) state_d = ST_DONE;
                else             state_d = ST_MEAS_WIDTH;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter and capture updates for the current state
    always_comb begin
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        tmo_cap_d   = tmo_cap_q;
        delay_cap_d = delay_cap_q;
        width_cap_d = width_cap_q;
        tflag_cap_d = tflag_cap_q;
        case (state_q)
            ST_IDLE: begin
                if (ref_rise_s) begin
                    tmo_cap_d   = timeout_i;
                    cnt_d       = CNT_ONE;
                    tflag_cap_d = 1'b0;
                    if (echo_rise_s) begin
                        delay_cap_d = CNT_ZERO;
                        wcnt_d      = CNT_ONE;
                    end else begin
                        wcnt_d      = wcnt_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT_ECHO: begin
                if (echo_rise_s) begin
                    delay_cap_d = cnt_q;
                    wcnt_d      = CNT_ONE;
                end else if (tmo_hit_s) begin
                    delay_cap_d = tmo_cap_q;
                    width_cap_d = CNT_ZERO;
                    tflag_cap_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_MEAS_WIDTH: begin
                if (echo_fall_s) begin
                    width_cap_d = wcnt_q;
                end else if (echo_r1_q && (wcnt_q != CNT_MAX)) begin
                    wcnt_d = wcnt_q + CNT_ONE;
                end else begin
                    wcnt_d = wcnt_q;
                end
            end
            ST_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Output logic: results are published in the DONE cycle and held afterwards
    always_comb begin
        delay_out_d = delay_out_q;
        width_out_d = width_out_q;
        timed_out_d = timed_out_q;
        valid_d     = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        if (state_q == ST_DONE) begin
            delay_out_d = delay_cap_q;
            width_out_d = width_cap_q;
            timed_out_d = tflag_cap_q;
            valid_d     = 1'b1;
        end else begin
            valid_d     = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q       <= CNT_ZERO;
            wcnt_q      <= CNT_ZERO;
            tmo_cap_q   <= CNT_ZERO;
            delay_cap_q <= CNT_ZERO;
            width_cap_q <= CNT_ZERO;
            tflag_cap_q <= 1'b0;
            delay_out_q <= CNT_ZERO;
            width_out_q <= CNT_ZERO;
            valid_q     <= 1'b0;
            timed_out_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            tmo_cap_q   <= tmo_cap_d;
            delay_cap_q <= delay_cap_d;
            width_cap_q <= width_cap_d;
            tflag_cap_q <= tflag_cap_d;
            delay_out_q <= delay_out_d;
            width_out_q <= width_out_d;
            valid_q     <= valid_d;
            timed_out_q <= timed_out_d;
            busy_q      <= busy_d;
        end
    end

    assign delay_out_o = delay_out_q;
    assign width_out_o = width_out_q;
    assign valid_o     = valid_q;
    assign timed_out_o = timed_out_q;
    assign busy_o      = busy_q;

endmodule
